// File: rtl/tx_intf_dma_sched.sv
// tx_intf_dma_sched: round-robin scheduler in front of the tx_intf AXIS DMA streamer.
// It arbitrates the tx queue requests, programs the symbol count, pulses start_1trans,
// watches the stream handshake for TLAST, reports per-queue completion and enforces an
// inter-transfer gap.
// Optional feature: define TX_DMA_SCHED_WATCHDOG_EN to abort a transfer that sees no beat
// for wd_cfg cycles. The abort pulses the streamer reset and reports queue_err.
module tx_intf_dma_sched #(
    parameter int NUM_QUEUE              = 4,
    parameter int MAX_BIT_NUM_DMA_SYMBOL = 14,
    parameter int GAP_BITS               = 4,
    parameter int WD_BITS                = 16,
    localparam int QW = (NUM_QUEUE > 1) ? $clog2(NUM_QUEUE) : 1
) (
    input  logic                                        M_AXIS_ACLK,
    input  logic                                        M_AXIS_ARESETN,
    input  logic                                        sched_en,
    input  logic [NUM_QUEUE-1:0]                        queue_req,
    input  logic [NUM_QUEUE*MAX_BIT_NUM_DMA_SYMBOL-1:0] queue_len,
    input  logic [GAP_BITS-1:0]                         gap_cfg,
    input  logic [WD_BITS-1:0]                          wd_cfg,
    output logic [NUM_QUEUE-1:0]                        queue_ack,
    output logic [NUM_QUEUE-1:0]                        queue_err,
    output logic                                        start_1trans,
    output logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]           M_AXIS_NUM_DMA_SYMBOL,
    output logic                                        endless_mode,
    output logic                                        dp_aresetn,
    input  logic                                        M_AXIS_TVALID,
    input  logic                                        M_AXIS_TREADY,
    input  logic                                        M_AXIS_TLAST,
    output logic                                        busy,
    output logic [QW-1:0]                               cur_queue
);

    localparam int MB = MAX_BIT_NUM_DMA_SYMBOL;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARB       = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_LAST = 3'd3,
        ST_GAP       = 3'd4
    } state_t;

    // Round-robin search starting just after the last winner; MSB of result = found.
    function automatic logic [QW:0] rr_pick(input logic [NUM_QUEUE-1:0] req,
                                           input logic [QW-1:0]        ptr);
        logic [QW:0] res;
        int          k;
        res = '0;
        for (int i = 1; i <= NUM_QUEUE; i++) begin
            k = (int'(ptr) + i) % NUM_QUEUE;
            if (!res[QW] && req[k]) begin
                res = {1'b1, k[QW-1:0]};
            end
        end
        return res;
    endfunction

    state_t                 state_q, state_d;
    logic [QW-1:0]          ptr_q, ptr_d;
    logic [QW-1:0]          cur_queue_q, cur_queue_d;
    logic [MB-1:0]          num_q, num_d;
    logic [GAP_BITS-1:0]    gap_cnt_q, gap_cnt_d;
    logic [NUM_QUEUE-1:0]   ack_q, ack_d;
    logic [NUM_QUEUE-1:0]   err_q, err_d;
    logic                   start_q, start_d;
    logic                   busy_q, busy_d;
    logic                   dp_aresetn_q, dp_aresetn_d;

    logic [QW:0]            pick_s;
    logic                   pick_found_s;
    logic [QW-1:0]          pick_idx_s;
    logic [MB-1:0]          pick_len_s;
    logic [GAP_BITS-1:0]    gap_len_s;
    logic                   beat_s;

`ifdef TX_DMA_SCHED_WATCHDOG_EN
    logic [WD_BITS-1:0]     wd_cnt_q, wd_cnt_d;
    logic [1:0]             dp_rst_cnt_q, dp_rst_cnt_d;
`else
    logic                   unused_wd_s;
    assign unused_wd_s = ^wd_cfg;
`endif

    // Arbitration candidate, its length and the effective gap length.
    always_comb begin
        pick_s       = rr_pick(queue_req, ptr_q);
        pick_found_s = pick_s[QW];
        pick_idx_s   = pick_s[QW-1:0];
        pick_len_s   = queue_len[int'(pick_idx_s)*MB +: MB];
        gap_len_s    = (gap_cfg == '0) ? GAP_BITS'(1) : gap_cfg;
        beat_s       = M_AXIS_TVALID && M_AXIS_TREADY;
    end

    // Next-state and next-output logic of the scheduler FSM.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cur_queue_d = cur_queue_q;
        num_d       = num_q;
        gap_cnt_d   = gap_cnt_q;
        ack_d       = '0;
        err_d       = '0;
`ifdef TX_DMA_SCHED_WATCHDOG_EN
        wd_cnt_d     = wd_cnt_q;
        dp_rst_cnt_d = (dp_rst_cnt_q != 2'd0) ? (dp_rst_cnt_q - 2'd1) : 2'd0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (sched_en && (|queue_req)) begin
                    state_d = ST_ARB;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARB: begin
                if (!pick_found_s) begin
                    // Request withdrawn before arbitration: silently go back.
                    state_d = ST_IDLE;
                end else begin
                    ptr_d       = pick_idx_s;
                    cur_queue_d = pick_idx_s;
                    if (pick_len_s == '0) begin
                        num_d             = '0;
                        err_d[pick_idx_s] = 1'b1;
                        gap_cnt_d         = GAP_BITS'(1);
                        state_d           = ST_GAP;
                    end else begin
                        num_d   = pick_len_s - MB'(1);
                        state_d = ST_START;
                    end
                end
            end
            ST_START: begin
`ifdef TX_DMA_SCHED_WATCHDOG_EN
                wd_cnt_d = '0;
`endif
                state_d = ST_WAIT_LAST;
            end
            ST_WAIT_LAST: begin
                if (beat_s && M_AXIS_TLAST) begin
                    ack_d[cur_queue_q] = 1'b1;
                    gap_cnt_d          = GAP_BITS'(1);
                    state_d            = ST_GAP;
`ifdef TX_DMA_SCHED_WATCHDOG_EN
                end else if (beat_s) begin
                    wd_cnt_d = '0;
                end else if ((wd_cfg != '0) && (wd_cnt_q == wd_cfg)) begin
                    // Stream stalled too long: reset the streamer and report an error.
                    err_d[cur_queue_q] = 1'b1;
                    dp_rst_cnt_d       = 2'd2;
                    gap_cnt_d          = GAP_BITS'(1);
                    state_d            = ST_GAP;
                end else begin
                    wd_cnt_d = (wd_cnt_q != '1) ? (wd_cnt_q + WD_BITS'(1)) : wd_cnt_q;
`endif
                end else begin
                    state_d = ST_WAIT_LAST;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q >= gap_len_s) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_BITS'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        start_d = (state_d == ST_START);
        busy_d  = (state_d != ST_IDLE);
`ifdef TX_DMA_SCHED_WATCHDOG_EN
        dp_aresetn_d = (dp_rst_cnt_d == 2'd0);
`else
        dp_aresetn_d = 1'b1;
`endif
    end

    // State and registered-output flops.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            state_q      <= ST_IDLE;
            ptr_q        <= QW'(NUM_QUEUE - 1);
            cur_queue_q  <= '0;
            num_q        <= '0;
            gap_cnt_q    <= '0;
            ack_q        <= '0;
            err_q        <= '0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            dp_aresetn_q <= 1'b1;
`ifdef TX_DMA_SCHED_WATCHDOG_EN
            wd_cnt_q     <= '0;
            dp_rst_cnt_q <= 2'd0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cur_queue_q  <= cur_queue_d;
            num_q        <= num_d;
            gap_cnt_q    <= gap_cnt_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            start_q      <= start_d;
            busy_q       <= busy_d;
            dp_aresetn_q <= dp_aresetn_d;
`ifdef TX_DMA_SCHED_WATCHDOG_EN
            wd_cnt_q     <= wd_cnt_d;
            dp_rst_cnt_q <= dp_rst_cnt_d;
`endif
        end
    end

    assign queue_ack             = ack_q;
    assign queue_err             = err_q;
    assign start_1trans          = start_q;
    assign M_AXIS_NUM_DMA_SYMBOL = num_q;
    assign endless_mode          = 1'b0;
    assign dp_aresetn            = dp_aresetn_q;
    assign busy                  = busy_q;
    assign cur_queue             = cur_queue_q;

endmodule

// File: tb/tb_tx_intf_dma_sched.sv
// Bench for tx_intf_dma_sched: directed scenarios, a small streamer, a requester that
// drops a request after its ack/err, and a transaction-level model checked every cycle.
module tb_tx_intf_dma_sched;
    localparam int NQ  = 4;
    localparam int MB  = 14;
    localparam int GB  = 4;
    localparam int WB  = 16;
    localparam int INF = 32'h3fffffff;
`ifdef TX_DMA_SCHED_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            sched_en = 1'b0;
    logic [NQ-1:0]   queue_req = '0;
    logic [MB-1:0]   len_a [NQ];
    logic [NQ*MB-1:0] queue_len;
    logic [GB-1:0]   gap_cfg = '0;
    logic [WB-1:0]   wd_cfg = '0;
    logic            tvalid = 1'b0, tready = 1'b1, tlast = 1'b0;
    logic [NQ-1:0]   queue_ack, queue_err;
    logic            start_1trans, endless_mode, dp_aresetn, busy;
    logic [MB-1:0]   num;
    logic [1:0]      cur_queue;

    assign queue_len = {len_a[3], len_a[2], len_a[1], len_a[0]};

    always #5 clk = ~clk;

    tx_intf_dma_sched dut (
        .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rst_n), .sched_en(sched_en),
        .queue_req(queue_req), .queue_len(queue_len), .gap_cfg(gap_cfg), .wd_cfg(wd_cfg),
        .queue_ack(queue_ack), .queue_err(queue_err), .start_1trans(start_1trans),
        .M_AXIS_NUM_DMA_SYMBOL(num), .endless_mode(endless_mode), .dp_aresetn(dp_aresetn),
        .M_AXIS_TVALID(tvalid), .M_AXIS_TREADY(tready), .M_AXIS_TLAST(tlast),
        .busy(busy), .cur_queue(cur_queue)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- requester: holds a request until its ack/err count is used up
    int req_left [NQ];

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NQ; i++) begin
            if (rst_n && (queue_ack[i] || queue_err[i]) && req_left[i] > 0) req_left[i]--;
            queue_req[i] = (req_left[i] > 0);
        end
    endtask

    task automatic request(input int q, input int n, input int len);
        req_left[q]  = n;
        len_a[q]     = MB'(len);
        queue_req[q] = 1'b1;
    endtask

    // ---------------- streamer: after a start pulse, emits NUM+1 beats, TLAST on the last
    int stall_after = -1;
    int s_beat = 0, s_n = 0;
    bit s_active = 1'b0, s_seen = 1'b0;

    initial begin : streamer
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n || !dp_aresetn) begin
                s_active = 1'b0;
                s_seen   = 1'b0;
            end else begin
                if (tvalid && tready) begin
                    s_beat++;
                    if (s_beat == s_n) s_active = 1'b0;
                end
                if (s_seen) begin
                    s_active = 1'b1;
                    s_beat   = 0;
                    s_seen   = 1'b0;
                end
                if (start_1trans) begin
                    s_seen = 1'b1;
                    s_n    = int'(num) + 1;
                end
            end
            tvalid = s_active;
            tlast  = s_active && (s_beat == s_n - 1);
            tready = !(s_active && stall_after >= 0 && s_beat >= stall_after);
        end
    end

    // ---------------- transaction-level model, compared every cycle
    int  cyc = 0;
    int  m_mode = 0;            // 0 free/gap, 1 arbitration cycle next, 2 transfer running
    int  m_busy_from = 0, m_idle_from = 0, m_wait_from = 0, m_idle_run = 0;
    int  m_ptr = NQ - 1, m_q = 0;
    int  m_num = 0;
    bit             sched_start [int];
    logic [NQ-1:0]  sched_ack [int];
    logic [NQ-1:0]  sched_err [int];
    bit             sched_dplo [int];

    function automatic int gap_len(input logic [GB-1:0] g);
        return (g == '0) ? 1 : int'(g);
    endfunction

    initial begin : model_check
        int w;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cyc = 0; m_mode = 0; m_busy_from = 0; m_idle_from = 0; m_ptr = NQ - 1;
                sched_start.delete(); sched_ack.delete(); sched_err.delete(); sched_dplo.delete();
            end else begin
                chk("start_1trans", 32'(start_1trans), 32'(sched_start.exists(cyc)));
                chk("queue_ack", 32'(queue_ack), 32'(sched_ack.exists(cyc) ? sched_ack[cyc] : 4'b0000));
                chk("queue_err", 32'(queue_err), 32'(sched_err.exists(cyc) ? sched_err[cyc] : 4'b0000));
                chk("busy", 32'(busy), 32'(cyc >= m_busy_from && cyc < m_idle_from));
                chk("dp_aresetn", 32'(dp_aresetn), 32'(!sched_dplo.exists(cyc)));
                chk("endless_mode", 32'(endless_mode), 32'd0);
                if (m_mode == 2) begin
                    chk("cur_queue", 32'(cur_queue), 32'(m_q));
                    chk("num_symbol", 32'(num), 32'(m_num));
                end
                // advance the model with the inputs the next clock edge will see
                case (m_mode)
                    0: if (cyc >= m_idle_from && sched_en && (|queue_req)) begin
                        m_busy_from = cyc + 1;
                        m_idle_from = INF;
                        m_mode      = 1;
                    end
                    1: begin
                        w = -1;
                        for (int i = 1; i <= NQ; i++) begin
                            if (w < 0 && queue_req[(m_ptr + i) % NQ]) w = (m_ptr + i) % NQ;
                        end
                        if (w < 0) begin
                            m_idle_from = cyc + 1;
                            m_mode      = 0;
                        end else if (len_a[w] == '0) begin
                            m_ptr = w;
                            sched_err[cyc + 1] = 4'b0001 << w;
                            m_idle_from = cyc + 1 + gap_len(gap_cfg);
                            m_mode      = 0;
                        end else begin
                            m_ptr = w; m_q = w; m_num = int'(len_a[w]) - 1;
                            sched_start[cyc + 1] = 1'b1;
                            m_wait_from = cyc + 2;
                            m_idle_run  = 0;
                            m_mode      = 2;
                        end
                    end
                    default: if (cyc >= m_wait_from) begin
                        if (tvalid && tready && tlast) begin
                            sched_ack[cyc + 1] = 4'b0001 << m_q;
                            m_idle_from = cyc + 1 + gap_len(gap_cfg);
                            m_mode      = 0;
                        end else if (tvalid && tready) begin
                            m_idle_run = 0;
                        end else if (WD_EN && wd_cfg != '0 && m_idle_run == int'(wd_cfg)) begin
                            sched_err[cyc + 1]  = 4'b0001 << m_q;
                            sched_dplo[cyc + 1] = 1'b1;
                            sched_dplo[cyc + 2] = 1'b1;
                            m_idle_from = cyc + 1 + gap_len(gap_cfg);
                            m_mode      = 0;
                        end else begin
                            m_idle_run++;
                        end
                    end
                endcase
                cyc++;
            end
        end
    end

    // ---------------- global time bound
    initial begin : time_bound
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time bound expired");
    end

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NQ; i++) req_left[i] = 0;
        queue_req   = '0;
        stall_after = -1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic drain(input int budget);
        int left;
        left = budget;
        while (left > 0 && (busy || (|queue_req))) begin
            tick();
            left--;
        end
        chk("drain_timeout", 32'(busy || (|queue_req)), 32'd0);
    endtask

    // ---------------- directed scenarios
    initial begin : main
        int lat, nb, prev_busy, last_beat, gap_dist, starts;
        bit got;
        logic [NQ-1:0] ack_seen, err_seen;
        int grants[$];
        int exp_grants[4];
        exp_grants = '{0, 2, 3, 0};
        for (int i = 0; i < NQ; i++) begin
            len_a[i] = '0;
            req_left[i] = 0;
        end

        // reset state
        tick(); tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(start_1trans), 32'd0);
        chk("rst_dp_aresetn", 32'(dp_aresetn), 32'd1);
        chk("rst_ack_err", 32'({queue_ack, queue_err}), 32'd0);
        chk("rst_num", 32'(num), 32'd0);
        rst_n = 1'b1;

        // 1: q1, len 5
        sched_en = 1'b1; gap_cfg = 4'd0;
        tick();
        request(1, 1, 5);
        lat = 0;
        for (int i = 0; i < 10 && !start_1trans; i++) begin tick(); lat++; end
        chk("t1_latency", 32'(lat), 32'd2);
        chk("t1_num", 32'(num), 32'd4);
        nb = 0; got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            tick();
            if (tvalid && tready) begin
                nb++;
                if (tlast) got = 1'b1;
            end
        end
        chk("t1_beats", 32'(nb), 32'd5);
        chk("t1_ack", 32'(queue_ack), 32'b0010);
        drain(50);

        // 2: q0,q2,q3 held, gap 3
        do_reset();
        gap_cfg = 4'd3;
        request(0, 2, 4); request(2, 1, 3); request(3, 1, 2);
        prev_busy = 0; last_beat = -1; gap_dist = -1;
        for (int i = 0; i < 400 && (busy || (|queue_req)); i++) begin
            tick();
            if (start_1trans) grants.push_back(int'(cur_queue));
            if (tvalid && tready && tlast && last_beat < 0) last_beat = i;
            if (busy && !prev_busy && last_beat >= 0 && gap_dist < 0) gap_dist = i - last_beat;
            prev_busy = int'(busy);
        end
        chk("t2_grant_count", 32'(grants.size()), 32'd4);
        for (int i = 0; i < 4 && i < grants.size(); i++) chk("t2_grant_order", 32'(grants[i]), 32'(exp_grants[i]));
        chk("t2_tlast_to_arb", 32'(gap_dist), 32'd4);

        // 3: q3 len 0 alongside q0
        gap_cfg = 4'd0;
        request(3, 1, 0); request(0, 1, 2);
        ack_seen = '0; err_seen = '0; starts = 0;
        for (int i = 0; i < 60 && (busy || (|queue_req)); i++) begin
            tick();
            ack_seen |= queue_ack; err_seen |= queue_err;
            if (start_1trans) starts++;
        end
        chk("t3_err", 32'(err_seen), 32'b1000);
        chk("t3_ack", 32'(ack_seen), 32'b0001);
        chk("t3_starts", 32'(starts), 32'd1);

        // 4: stall after 2 beats with wd_cfg 10
        gap_cfg = 4'd1; wd_cfg = 16'd10; stall_after = 2;
        request(1, 1, 6);
        err_seen = '0; nb = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            err_seen |= queue_err;
            if (!dp_aresetn) nb++;
        end
`ifdef TX_DMA_SCHED_WATCHDOG_EN
        chk("t4_dp_low_cycles", 32'(nb), 32'd2);
        chk("t4_err", 32'(err_seen), 32'b0010);
        chk("t4_idle_after", 32'(busy), 32'd0);
        // 5 prep: a stalled transfer with the watchdog disabled
        wd_cfg = 16'd0;
        request(2, 1, 6);
        for (int i = 0; i < 20; i++) tick();
`else
        chk("t4_dp_low_cycles", 32'(nb), 32'd0);
        chk("t4_err", 32'(err_seen), 32'b0000);
        chk("t4_still_busy", 32'(busy), 32'd1);
        wd_cfg = 16'd0;
`endif

        // 5: asynchronous reset in the middle of WAIT_LAST
        chk("t5_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_dp_aresetn", 32'(dp_aresetn), 32'd1);
        chk("t5_outs", 32'({queue_ack, queue_err, start_1trans}), 32'd0);
        for (int i = 0; i < NQ; i++) req_left[i] = 0;
        queue_req = '0; stall_after = -1;
        tick(); tick();
        rst_n = 1'b1;
        request(0, 1, 3); request(3, 1, 3);
        for (int i = 0; i < 10 && !start_1trans; i++) tick();
        chk("t5_first_grant", 32'(cur_queue), 32'd0);
        drain(100);

        // 6: sched_en dropped during a transfer
        gap_cfg = 4'd2;
        request(1, 1, 4); request(2, 1, 4);
        for (int i = 0; i < 10 && !start_1trans; i++) tick();
        chk("t6_grant", 32'(cur_queue), 32'd1);
        sched_en = 1'b0;
        ack_seen = '0; starts = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            ack_seen |= queue_ack;
            if (start_1trans) starts++;
        end
        chk("t6_ack", 32'(ack_seen), 32'b0010);
        chk("t6_no_new_start", 32'(starts), 32'd0);
        chk("t6_busy_low", 32'(busy), 32'd0);
        sched_en = 1'b1;
        ack_seen = '0;
        for (int i = 0; i < 40 && (|queue_req); i++) begin
            tick();
            ack_seen |= queue_ack;
        end
        chk("t6_resume_ack", 32'(ack_seen), 32'b0100);
        drain(50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
